// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, RD_WAIT)
//   owner_t      : which requester owns the outstanding read
//   STARVE_CNT_W : width of the fetch starvation counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {IDLE, RD_WAIT} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, the load/store requester and the memory unit
// port that the arbiter multiplexes between them.
//   slave  : arbiter view (takes requests, returns grants/data, drives memory)
//   master : requester/memory view (issues requests, supplies mem_rdata)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [31:0]           if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_write_en;
  logic                  mem_read;
  logic [31:0]           mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_write_en, mem_read
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_write_en, mem_read
  );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Counts consecutive data grants taken while a fetch is waiting, saturating
// at LIMIT. at_limit tells the arbiter to hand the port to fetch.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : data grant while fetch pending
//   clr      : fetch granted or no fetch pending (wins over inc)
//   at_limit : count has reached LIMIT
// ---------------------------------------------------------------------------
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory/IO port (1-cycle registered read latency) between the
// instruction fetch requester and the load/store requester. Data wins by
// default; after STARVE_LIMIT consecutive data grants with fetch waiting,
// fetch is forced through. One transaction outstanding at a time.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : requester and memory signals (slave modport)
//   busy     : high while waiting for read data (RD_WAIT)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           d_rdata_q, d_rdata_d;

  logic                  data_win, fetch_win, at_limit;
  logic                  if_gnt, d_gnt, rd_en, wr_en;
  logic                  if_rvalid, d_rvalid;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [31:0]           wdata_sel;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (d_gnt && bus.if_req),
    .clr      (if_gnt || !bus.if_req),
    .at_limit (at_limit)
  );

  // Fetch only overrides data once the starvation limit is reached.
  assign data_win  = bus.d_req && !(bus.if_req && at_limit);
  assign fetch_win = !data_win && bus.if_req;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are combinational, so they must be masked while in reset.
        if (rst) begin
          if (data_win) begin
            d_gnt     = 1'b1;
            addr_sel  = bus.d_addr;
            wdata_sel = bus.d_wdata;
            if (bus.d_we) begin
              wr_en = 1'b1;
            end else begin
              rd_en   = 1'b1;
              owner_d = OWN_D;
              state_d = RD_WAIT;
            end
          end else if (fetch_win) begin
            if_gnt   = 1'b1;
            addr_sel = bus.if_addr;
            rd_en    = 1'b1;
            owner_d  = OWN_IF;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if_rvalid = (owner_q == OWN_IF);
        d_rvalid  = (owner_q == OWN_D);
        owner_d   = OWN_NONE;
        state_d   = IDLE;
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    endcase
    // Read data passes straight through in the valid cycle and is then held.
    if_rdata_d = if_rvalid ? bus.mem_rdata : if_rdata_q;
    d_rdata_d  = d_rvalid  ? bus.mem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.if_gnt       = if_gnt;
  assign bus.d_gnt        = d_gnt;
  assign bus.if_rvalid    = if_rvalid;
  assign bus.d_rvalid     = d_rvalid;
  assign bus.if_rdata     = if_rdata_d;
  assign bus.d_rdata      = d_rdata_d;
  assign bus.mem_addr     = addr_sel;
  assign bus.mem_wdata    = wdata_sel;
  assign bus.mem_write_en = wr_en;
  assign bus.mem_read     = rd_en;
  assign busy             = (state_q == RD_WAIT);

endmodule
